icache_mem_bridge: RTL and testbench

ICACHE_MEM_BRIDGE -- requirements
Module: icache_mem_bridge

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_mem_bridge.sv | 159 +++++++++++++++
 tb/tb_icache_mem_bridge.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// icache_pkg
// Purpose: definitions shared by the instruction cache and its memory bridge.
//   - icache_state_e : bridge burst state (IDLE / ISSUE / DRAIN)
//   - calc_bl_w      : width of a burst-length field for a given block size
//   - calc_stride    : byte stride between consecutive words
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } icache_state_e;

  // One extra bit so that the full block size itself is representable.
  function automatic int calc_bl_w(input int block_size);
    return $clog2(block_size) + 1;
  endfunction

  function automatic int calc_stride(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/icache_mem_bridge.sv
// icache_mem_bridge
// Purpose: turns a single-cycle cache burst request into a sequence of word
// reads to the instruction RAM, keeping at most MAX_OUTSTANDING reads in
// flight, and returns the in-order read data as registered beats.
//
// State  | meaning
// IDLE   | ready for a burst request; stale RAM responses are dropped
// ISSUE  | issuing word reads; responses may already be returning
// DRAIN  | all reads granted; waiting for remaining responses
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   mem_req/mem_addr/mem_burst_len  burst request (len = beats-1, clamped)
//   mem_ready                     high only in IDLE
//   mem_valid/mem_data/mem_last   returned beat, data, final-beat flag
//   ram_req/ram_addr/ram_gnt      word read request handshake
//   ram_rvalid/ram_rdata          in-order read response
//   stat_bursts/stat_beats        saturating counters, present only when
//                                 ICACHE_MEM_BRIDGE_STATS_EN is defined
module icache_mem_bridge
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BLOCK_SIZE      = 8,
  parameter int MAX_OUTSTANDING = 2,
  localparam int BL_W           = calc_bl_w(BLOCK_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BL_W-1:0]       mem_burst_len,
  output logic                  mem_ready,
  output logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_last,
  output logic                  ram_req,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_gnt,
  input  logic                  ram_rvalid,
  input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef ICACHE_MEM_BRIDGE_STATS_EN
  ,
  output logic [31:0]           stat_bursts,
  output logic [31:0]           stat_beats
`endif
);

  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int STRIDE = calc_stride(DATA_WIDTH);

  icache_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [BL_W-1:0]       beats_q, beats_d;
  logic [BL_W-1:0]       issued_q, issued_d;
  logic [BL_W-1:0]       returned_q, returned_d;
  logic [OUT_W-1:0]      outst_q, outst_d;
  logic                  mem_valid_q, mem_last_q;
  logic [DATA_WIDTH-1:0] mem_data_q;

  logic accept, grant, beat_in;

  assign accept    = (state_q == ST_IDLE) && mem_req;
  assign ram_req   = (state_q == ST_ISSUE) && (issued_q < beats_q) &&
                     (outst_q < OUT_W'(MAX_OUTSTANDING));
  assign ram_addr  = base_q + ADDR_WIDTH'(issued_q) * ADDR_WIDTH'(STRIDE);
  assign grant     = ram_req && ram_gnt;
  // Responses arriving in IDLE belong to an abandoned burst.
  assign beat_in   = ram_rvalid && (state_q != ST_IDLE);

  assign mem_ready = (state_q == ST_IDLE);
  assign mem_valid = mem_valid_q;
  assign mem_data  = mem_data_q;
  assign mem_last  = mem_last_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    beats_d    = beats_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    outst_d    = outst_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          state_d    = ST_ISSUE;
          base_d     = mem_addr;
          beats_d    = (mem_burst_len > BL_W'(BLOCK_SIZE - 1)) ?
                       BL_W'(BLOCK_SIZE) : mem_burst_len + BL_W'(1);
          issued_d   = '0;
          returned_d = '0;
          outst_d    = '0;
        end
      end
      ST_ISSUE: begin
        if (grant && (issued_q + BL_W'(1) == beats_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (mem_valid_q && mem_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) begin
      if (grant)   issued_d   = issued_q + BL_W'(1);
      if (beat_in) returned_d = returned_q + BL_W'(1);
      // Simultaneous grant and response leave the count unchanged.
      if (grant && !beat_in) outst_d = outst_q + OUT_W'(1);
      else if (!grant && beat_in && (outst_q != '0)) outst_d = outst_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      beats_q     <= '0;
      issued_q    <= '0;
      returned_q  <= '0;
      outst_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_last_q  <= 1'b0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      beats_q     <= beats_d;
      issued_q    <= issued_d;
      returned_q  <= returned_d;
      outst_q     <= outst_d;
      mem_valid_q <= beat_in;
      mem_last_q  <= beat_in && (returned_q == beats_q - BL_W'(1));
      if (beat_in) mem_data_q <= ram_rdata;
    end
  end

`ifdef ICACHE_MEM_BRIDGE_STATS_EN
  logic [31:0] stat_bursts_q, stat_beats_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bursts_q <= '0;
      stat_beats_q  <= '0;
    end else begin
      if (accept && (stat_bursts_q != '1)) stat_bursts_q <= stat_bursts_q + 32'd1;
      if (beat_in && (stat_beats_q != '1)) stat_beats_q  <= stat_beats_q + 32'd1;
    end
  end

  assign stat_bursts = stat_bursts_q;
  assign stat_beats  = stat_beats_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_icache_mem_bridge.sv
module tb_icache_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_burst_len = '0;
  logic        mem_ready, mem_valid, mem_last, ram_req;
  logic [31:0] mem_data, ram_addr;
  logic        ram_gnt = 1'b0;
  logic        ram_rvalid = 1'b0;
  logic [31:0] ram_rdata = '0;
`ifdef ICACHE_MEM_BRIDGE_STATS_EN
  logic [31:0] stat_bursts, stat_beats;
`endif

  int checks = 0;
  int errors = 0;

  icache_mem_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_SIZE(8), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_burst_len(mem_burst_len),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_data(mem_data), .mem_last(mem_last),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_gnt(ram_gnt),
    .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata)
`ifdef ICACHE_MEM_BRIDGE_STATS_EN
    , .stat_bursts(stat_bursts), .stat_beats(stat_beats)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM model: decides grant/response mid-cycle for the next rising edge.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] data; logic last; } beat_t;
  pend_t       pend[$];
  beat_t       rcv[$];
  logic [31:0] granted[$];
  int cyc = 0;
  int lat = 1;
  int stall_beat = -1;
  int stall_left = 0;
  int stalled = 0;
  int n_granted = 0;
  int max_pend = 0;
  logic [31:0] stall_addr = '0;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(negedge clk) begin
    pend_t p;
    cyc++;
    ram_rvalid = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      ram_rvalid = 1'b1;
      ram_rdata  = rd_of(p.addr);
    end
    ram_gnt = 1'b0;
    if (ram_req === 1'b1) begin
      if (stall_left > 0 && n_granted == stall_beat) begin
        stall_left--;
        stalled++;
        chk("stall_addr_held", ram_addr, stall_addr);
      end else begin
        ram_gnt = 1'b1;
        pend.push_back('{addr: ram_addr, due: cyc + lat});
        granted.push_back(ram_addr);
        n_granted++;
      end
    end
    if (pend.size() > max_pend) max_pend = pend.size();
  end

  always @(negedge clk) begin
    if (mem_valid === 1'b1) rcv.push_back('{data: mem_data, last: mem_last});
  end

  // Caller is positioned at a falling edge; request is sampled on the next rise.
  task automatic do_burst(input logic [31:0] a, input logic [3:0] len);
    rcv.delete();
    granted.delete();
    n_granted = 0;
    max_pend = 0;
    stalled = 0;
    mem_req = 1'b1;
    mem_addr = a;
    mem_burst_len = len;
    @(negedge clk);
    mem_req = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_ready !== 1'b1 && n < 300);
    chk({tag, "_ready_timeout"}, {31'd0, mem_ready}, 32'd1);
  endtask

  task automatic check_burst(input string tag, input logic [31:0] base, input int nb);
    chk({tag, "_beats"}, rcv.size(), nb);
    chk({tag, "_grants"}, granted.size(), nb);
    for (int i = 0; i < nb; i++) begin
      if (i < granted.size()) chk({tag, "_addr"}, granted[i], base + 32'(4 * i));
      if (i < rcv.size()) begin
        chk({tag, "_data"}, rcv[i].data, rd_of(base + 32'(4 * i)));
        chk({tag, "_last"}, {31'd0, rcv[i].last}, {31'd0, (i == nb - 1)});
      end
    end
  endtask

  initial begin
    int n;
    // Reset values
    #2;
    chk("rst_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_last", {31'd0, mem_last}, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait RAM, 8-beat burst
    lat = 1;
    do_burst(32'h100, 4'd7);
    wait_ready("zw");
    check_burst("zw", 32'h100, 8);
    chk("zw_max_out", max_pend, 32'd1);

    // Back-to-back request, grant stalled 3 cycles on beat 2
    stall_beat = 2;
    stall_left = 3;
    stall_addr = 32'h188;
    do_burst(32'h180, 4'd7);
    wait_ready("stall");
    check_burst("stall", 32'h180, 8);
    chk("stall_cycles", stalled, 32'd3);
    stall_beat = -1;

`ifdef ICACHE_MEM_BRIDGE_STATS_EN
    chk("stat_bursts", stat_bursts, 32'd2);
    chk("stat_beats", stat_beats, 32'd16);
`endif

    // Slow responses: never more than 2 reads in flight
    lat = 5;
    do_burst(32'h240, 4'd3);
    wait_ready("slow");
    check_burst("slow", 32'h240, 4);
    chk("slow_max_out", max_pend, 32'd2);

    // Over-long length is clamped; request during a burst is ignored
    lat = 1;
    repeat (3) @(negedge clk);
    do_burst(32'h300, 4'd15);
    @(negedge clk);
    mem_req = 1'b1;
    mem_addr = 32'h900;
    mem_burst_len = 4'd2;
    @(negedge clk);
    mem_req = 1'b0;
    wait_ready("clamp");
    check_burst("clamp", 32'h300, 8);

    // Reset mid-burst, stale responses must be dropped
    lat = 3;
    do_burst(32'h400, 4'd7);
    n = 0;
    while (rcv.size() < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_reach3", {31'd0, rcv.size() >= 3}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("mid_rst_ram_req", {31'd0, ram_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rcv.delete();
    repeat (10) @(negedge clk);
    chk("stale_dropped", rcv.size(), 32'd0);
    chk("post_rst_ready", {31'd0, mem_ready}, 32'd1);

    lat = 1;
    do_burst(32'h200, 4'd7);
    wait_ready("after_rst");
    check_burst("after_rst", 32'h200, 8);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
